// File: rtl/chronometer_ctrl_pkg.sv
// Shared types and defaults for the chronometer controller slice.
package chrono_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        FULL  = 3'd4
    } state_t;

    localparam int CLEAR_CYCLES_DEF = 2;
    localparam int LAP_DEPTH_DEF    = 4;

    // Width needed to hold an entry count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/chronometer_ctrl_if.sv
// Lap read port: the controller owns the FIFO, a display/UART reader drains it.
interface chronometer_ctrl_if #(
    parameter int TIME_W  = 10,
    parameter int COUNT_W = chrono_pkg::count_width(chrono_pkg::LAP_DEPTH_DEF)
) ();

    logic               lap_rd;
    logic [TIME_W-1:0]  lap_data;
    logic               lap_empty;
    logic               lap_full;
    logic [COUNT_W-1:0] lap_count;
    logic               lap_drop;

    modport master (
        input  lap_rd,
        output lap_data,
        output lap_empty,
        output lap_full,
        output lap_count,
        output lap_drop
    );

    modport slave (
        output lap_rd,
        input  lap_data,
        input  lap_empty,
        input  lap_full,
        input  lap_count,
        input  lap_drop
    );

endinterface

// File: rtl/chronometer_ctrl_lap_fifo.sv
// Small circular lap buffer with first-word fall-through head and flush.
module lap_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a simultaneous push needs, so full does not block it.
    always_comb begin
        empty   = (count == '0);
        full    = (count == COUNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        data    = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/chronometer_ctrl.sv
// Sequences one chronometer from start/stop and lap/reset button pulses.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | chronometer stopped, waiting for a start or a clear
//   CLEAR | chrono_reset held for CLEAR_CYCLES, then go to clear_target
//   RUN   | counting; lap pulses capture record_time into the FIFO
//   PAUSE | count held; start resumes without clearing
//   FULL  | terminal count reached; only a clear leaves this state
module chronometer_ctrl
    import chrono_pkg::*;
#(
    parameter int LIMIT_RECORD_TIMER = 1000,
    parameter int TIME_W             = $clog2(LIMIT_RECORD_TIMER),
    parameter int LAP_DEPTH          = LAP_DEPTH_DEF,
    parameter int CLEAR_CYCLES       = CLEAR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              lap_reset,
    input  logic [TIME_W-1:0] record_time,
    output logic              chrono_reset,
    output logic              chrono_enable,
    output logic              running,
    output logic              overflow,
    chronometer_ctrl_if.master lap
);

    localparam int                CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]  CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [TIME_W-1:0] LIMIT_M1 = TIME_W'(LIMIT_RECORD_TIMER - 1);

    state_t            state;
    state_t            clear_target;
    logic [CLR_W-1:0]  clear_cnt;
    logic              fifo_push;
    logic              fifo_flush;

    // Lap capture only while running; a lap/reset pulse anywhere else except CLEAR is a clear.
    always_comb begin
        fifo_push  = (state == RUN) && lap_reset;
        fifo_flush = lap_reset && ((state == IDLE) || (state == PAUSE) || (state == FULL));
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (lap.lap_rd),
        .flush (fifo_flush),
        .din   (record_time),
        .data  (lap.lap_data),
        .empty (lap.lap_empty),
        .full  (lap.lap_full),
        .count (lap.lap_count)
    );

    // Controller FSM with all chronometer-facing outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clear_target  <= IDLE;
            clear_cnt     <= '0;
            chrono_reset  <= 1'b0;
            chrono_enable <= 1'b0;
            running       <= 1'b0;
            overflow      <= 1'b0;
            lap.lap_drop  <= 1'b0;
        end else begin
            // A full FIFO only rejects the lap when no pop frees a slot that cycle.
            lap.lap_drop <= fifo_push && lap.lap_full && !lap.lap_rd;
            case (state)
                IDLE: begin
                    if (lap_reset) begin
                        state        <= CLEAR;
                        clear_target <= IDLE;
                        clear_cnt    <= CLR_LOAD;
                        chrono_reset <= 1'b1;
                    end else if (start_stop) begin
                        state        <= CLEAR;
                        clear_target <= RUN;
                        clear_cnt    <= CLR_LOAD;
                        chrono_reset <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clear_cnt == '0) begin
                        state         <= clear_target;
                        chrono_reset  <= 1'b0;
                        chrono_enable <= (clear_target == RUN);
                        running       <= (clear_target == RUN);
                    end else begin
                        clear_cnt <= clear_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (record_time >= LIMIT_M1) begin
                        state         <= FULL;
                        chrono_enable <= 1'b0;
                        running       <= 1'b0;
                        overflow      <= 1'b1;
                    end else if (start_stop) begin
                        state         <= PAUSE;
                        chrono_enable <= 1'b0;
                        running       <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (lap_reset) begin
                        state        <= CLEAR;
                        clear_target <= IDLE;
                        clear_cnt    <= CLR_LOAD;
                        chrono_reset <= 1'b1;
                    end else if (start_stop) begin
                        state         <= RUN;
                        chrono_enable <= 1'b1;
                        running       <= 1'b1;
                    end
                end
                FULL: begin
                    if (lap_reset) begin
                        state        <= CLEAR;
                        clear_target <= IDLE;
                        clear_cnt    <= CLR_LOAD;
                        chrono_reset <= 1'b1;
                        overflow     <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    chrono_reset  <= 1'b0;
                    chrono_enable <= 1'b0;
                    running       <= 1'b0;
                    overflow      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chronometer_ctrl.sv
// Directed plan followed by random pulses, checked against a queue-based model.
module tb_chronometer_ctrl;

    localparam int LIMIT = 1000;
    localparam int TW    = 10;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CLRC  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_CLR   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_FULL  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_stop;
    logic          lap_reset;
    logic [TW-1:0] record_time;
    logic          chrono_reset;
    logic          chrono_enable;
    logic          running;
    logic          overflow;

    chronometer_ctrl_if #(.TIME_W(TW), .COUNT_W(CW)) lap_if ();

    chronometer_ctrl #(
        .LIMIT_RECORD_TIMER (LIMIT),
        .LAP_DEPTH          (DEPTH),
        .CLEAR_CYCLES       (CLRC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_stop    (start_stop),
        .lap_reset     (lap_reset),
        .record_time   (record_time),
        .chrono_reset  (chrono_reset),
        .chrono_enable (chrono_enable),
        .running       (running),
        .overflow      (overflow),
        .lap           (lap_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int            m_mode;
    int            m_target;
    int            m_left;
    bit            m_drop;
    logic [TW-1:0] m_q[$];
    int            cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_clear(input int tgt);
        m_mode   = M_CLR;
        m_target = tgt;
        m_left   = CLRC;
    endtask

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model(input bit ss, input bit lr, input bit rd, input logic [TW-1:0] rt, input bit r);
        bit flush;
        bit push;
        bit popped;
        m_drop = 1'b0;
        flush  = 1'b0;
        push   = 1'b0;
        if (r) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_q.delete();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (lr) begin flush = 1'b1; start_clear(M_IDLE); end
                else if (ss) start_clear(M_RUN);
            end
            M_CLR: begin
                m_left--;
                if (m_left == 0) m_mode = m_target;
            end
            M_RUN: begin
                push = lr;
                if (int'(rt) >= LIMIT - 1) m_mode = M_FULL;
                else if (ss) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (lr) begin flush = 1'b1; start_clear(M_IDLE); end
                else if (ss) m_mode = M_RUN;
            end
            default: begin
                if (lr) begin flush = 1'b1; start_clear(M_IDLE); end
            end
        endcase
        if (flush) begin
            m_q.delete();
        end else begin
            popped = rd && (m_q.size() > 0);
            if (push && m_q.size() == DEPTH && !popped) begin
                m_drop = 1'b1;
            end else begin
                if (popped) void'(m_q.pop_front());
                if (push) m_q.push_back(rt);
            end
        end
    endtask

    task automatic check_all();
        chk("chrono_reset",  32'(chrono_reset),      32'(m_mode == M_CLR));
        chk("chrono_enable", 32'(chrono_enable),     32'(m_mode == M_RUN));
        chk("running",       32'(running),           32'(m_mode == M_RUN));
        chk("overflow",      32'(overflow),          32'(m_mode == M_FULL));
        chk("lap_count",     32'(lap_if.lap_count),  32'(m_q.size()));
        chk("lap_empty",     32'(lap_if.lap_empty),  32'(m_q.size() == 0));
        chk("lap_full",      32'(lap_if.lap_full),   32'(m_q.size() == DEPTH));
        chk("lap_drop",      32'(lap_if.lap_drop),   32'(m_drop));
        chk("lap_data",      32'(lap_if.lap_data),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    task automatic step(input bit ss, input bit lr, input bit rd, input logic [TW-1:0] rt, input bit r = 1'b0);
        rst            = r;
        start_stop     = ss;
        lap_reset      = lr;
        lap_if.lap_rd  = rd;
        record_time    = rt;
        @(posedge clk);
        model(ss, lr, rd, rt, r);
        #1;
        check_all();
    endtask

    initial begin
        bit ss;
        bit lr;
        bit rd;
        bit r;
        rst           = 1'b1;
        start_stop    = 1'b0;
        lap_reset     = 1'b0;
        lap_if.lap_rd = 1'b0;
        record_time   = '0;
        m_mode        = M_IDLE;
        m_target      = M_IDLE;
        m_left        = 0;
        m_drop        = 1'b0;
        cnt           = 0;

        // Plan 1: reset, then start goes through a two-cycle clear into RUN
        repeat (3) step(0, 0, 0, 0, 1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_lap_data", 32'(lap_if.lap_data), 32'd0);
        repeat (7) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t1_clr_c11", 32'(chrono_reset), 32'd1);
        step(0, 0, 0, 0);
        chk("t1_clr_c12", 32'(chrono_reset), 32'd1);
        step(0, 0, 0, 0);
        chk("t1_en_c13", 32'(chrono_enable), 32'd1);
        chk("t1_running", 32'(running), 32'd1);

        // Plan 2: two laps then a pop
        step(0, 1, 0, 10'd137);
        step(0, 1, 0, 10'd402);
        chk("t2_count2", 32'(lap_if.lap_count), 32'd2);
        chk("t2_head137", 32'(lap_if.lap_data), 32'd137);
        step(0, 0, 1, 10'd410);
        chk("t2_head402", 32'(lap_if.lap_data), 32'd402);
        chk("t2_count1", 32'(lap_if.lap_count), 32'd1);

        // Plan 3: fill, drop on overfill, push+pop while full
        step(0, 0, 1, 10'd420);
        chk("t3_empty", 32'(lap_if.lap_empty), 32'd1);
        step(0, 1, 0, 10'd10);
        step(0, 1, 0, 10'd20);
        step(0, 1, 0, 10'd30);
        step(0, 1, 0, 10'd40);
        chk("t3_full", 32'(lap_if.lap_full), 32'd1);
        step(0, 1, 0, 10'd50);
        chk("t3_drop", 32'(lap_if.lap_drop), 32'd1);
        chk("t3_count4", 32'(lap_if.lap_count), 32'd4);
        step(0, 0, 0, 10'd55);
        chk("t3_drop_once", 32'(lap_if.lap_drop), 32'd0);
        step(0, 1, 1, 10'd60);
        chk("t3_head20", 32'(lap_if.lap_data), 32'd20);
        chk("t3_count_kept", 32'(lap_if.lap_count), 32'd4);
        chk("t3_no_drop", 32'(lap_if.lap_drop), 32'd0);
        repeat (4) step(0, 0, 1, 10'd70);
        chk("t3_drained", 32'(lap_if.lap_empty), 32'd1);

        // Plan 4: lap and pause together, resume without clear
        step(1, 1, 0, 10'd250);
        chk("t4_lap250", 32'(lap_if.lap_data), 32'd250);
        chk("t4_paused", 32'(chrono_enable), 32'd0);
        step(1, 0, 0, 10'd250);
        chk("t4_resumed", 32'(running), 32'd1);
        chk("t4_no_clear", 32'(chrono_reset), 32'd0);

        // Plan 5: terminal count, ignored start, clear back to IDLE
        step(0, 0, 0, 10'd999);
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_en_off", 32'(chrono_enable), 32'd0);
        step(1, 0, 0, 10'd999);
        chk("t5_ss_ignored", 32'(overflow), 32'd1);
        step(0, 1, 0, 10'd999);
        chk("t5_clr1", 32'(chrono_reset), 32'd1);
        chk("t5_flushed", 32'(lap_if.lap_empty), 32'd1);
        chk("t5_ovf_off", 32'(overflow), 32'd0);
        step(0, 0, 0, 10'd0);
        chk("t5_clr2", 32'(chrono_reset), 32'd1);
        step(0, 0, 0, 10'd0);
        chk("t5_idle", 32'(chrono_reset), 32'd0);

        // Plan 6: rst with laps stored, and rst partway through CLEAR
        step(1, 0, 0, 10'd0);
        step(0, 0, 0, 10'd0);
        step(0, 0, 0, 10'd0);
        step(0, 1, 0, 10'd5);
        step(0, 1, 0, 10'd6);
        step(0, 1, 0, 10'd7);
        chk("t6_three", 32'(lap_if.lap_count), 32'd3);
        step(0, 0, 0, 10'd8, 1);
        chk("t6_rst_count", 32'(lap_if.lap_count), 32'd0);
        step(1, 0, 0, 10'd0);
        step(0, 0, 0, 10'd0, 1);
        chk("t6_mid_clear", 32'(chrono_reset), 32'd0);
        step(0, 0, 0, 10'd0);
        chk("t6_stays_idle", 32'(chrono_enable), 32'd0);

        // Random pulses with a crude chronometer advancing while enabled
        for (int i = 0; i < 3000; i++) begin
            ss = ($urandom % 40) == 0;
            lr = ($urandom % 10) == 0;
            rd = ($urandom % 4) == 0;
            r  = ($urandom % 500) == 0;
            step(ss, lr, rd, TW'(cnt), r);
            if (m_mode == M_CLR) cnt = 0;
            else if (m_mode == M_RUN) begin
                cnt = cnt + int'($urandom_range(0, 15));
                if (cnt > LIMIT - 1) cnt = LIMIT - 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chronometer_ctrl.md
Name: chronometer_ctrl

Overview:
Control FSM that sequences one chronometer instance from two debounced, single-cycle button pulses: start/stop and lap/reset.
- Drives the chronometer's reset and enable inputs.
- Detects when the count reaches its limit.
- Captures lap times into a small FIFO that a display or UART reader drains.
- Sits between the button debouncers and the chronometer, in the top level of the board design.

Parameters:
LIMIT_RECORD_TIMER, 1000, terminal count of the chronometer; must match the instance it controls
TIME_W, $clog2(LIMIT_RECORD_TIMER), width of time values
LAP_DEPTH, 4, lap FIFO entries (power of two, >=2)
CLEAR_CYCLES, 2, cycles chrono_reset is held high per clear (>=1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
start_stop  in  1  one-cycle pulse, start/pause/resume
lap_reset  in  1  one-cycle pulse; lap capture while running, clear otherwise
record_time  in  TIME_W  current chronometer count
chrono_reset  out  1  to the chronometer's reset input
chrono_enable  out  1  to the chronometer's count-enable input
running  out  1  high in RUN
overflow  out  1  high in FULL
lap_rd  in  1  pop request for the lap FIFO
lap_data  out  TIME_W  head of the lap FIFO (valid when !lap_empty)
lap_empty  out  1  FIFO empty
lap_full  out  1  FIFO full
lap_count  out  $clog2(LAP_DEPTH+1)  entries stored
lap_drop  out  1  one-cycle pulse: lap requested while FIFO full, value discarded

Behaviour:
Reset and output registration:
- While rst=1: state=IDLE, chrono_reset=0, chrono_enable=0, running=0, overflow=0, lap_drop=0, FIFO empty, lap_count=0, lap_data=0.
- All outputs are registered. Any state change is visible on outputs the cycle after the triggering pulse.

States: IDLE, CLEAR, RUN, PAUSE, FULL. CLEAR carries a return target (RUN or IDLE) and a down-counter loaded with CLEAR_CYCLES.
- IDLE:
  - start_stop -> CLEAR(target RUN).
  - lap_reset -> CLEAR(target IDLE) and flush FIFO.
  - Both asserted together -> lap_reset wins.
- CLEAR:
  - chrono_reset=1, chrono_enable=0 for exactly CLEAR_CYCLES cycles, then go to the target state.
  - Button pulses during CLEAR are ignored.
- RUN:
  - chrono_enable=1, running=1.
  - lap_reset -> push record_time, as sampled in the pulse cycle; stay in RUN. If FIFO full and no simultaneous pop: discard the value and pulse lap_drop.
  - start_stop -> PAUSE.
  - Both pulses in the same cycle -> capture the lap AND go to PAUSE.
  - record_time >= LIMIT_RECORD_TIMER-1 -> FULL. This has priority over start_stop; a lap pulse in that same cycle is still captured.
- PAUSE:
  - chrono_enable=0; count holds.
  - start_stop -> RUN, with no clear.
  - lap_reset -> CLEAR(target IDLE) and flush FIFO; lap_reset wins if both are asserted.
- FULL:
  - chrono_enable=0, overflow=1; start_stop ignored.
  - lap_reset -> CLEAR(target IDLE) and flush FIFO.

Lap FIFO:
- Circular buffer with read and write pointers of width $clog2(LAP_DEPTH), which wrap naturally.
- lap_data is combinational from the head entry (first-word fall-through).
- lap_rd when empty is ignored.
- Push and pop in the same cycle: both succeed; lap_count is unchanged. This holds even when full, because the pop frees the slot.
- Flush has priority over push and pop issued in the same cycle.
- lap_count saturates at LAP_DEPTH. lap_full = (lap_count==LAP_DEPTH).
- FIFO contents survive start/stop and PAUSE; only a clear or rst empties them.

Reset mid-operation:
- rst in any state, including partway through CLEAR, returns to IDLE on the next edge.
- The chronometer itself is not cleared by rst. A subsequent start always passes through CLEAR first.

Decomposition:
- Package chrono_pkg holds:
  - state enum (IDLE, CLEAR, RUN, PAUSE, FULL) with 3-bit encoding;
  - the CLEAR_CYCLES default;
  - a helper function for the lap_count width.
- One sub-module: lap_fifo (parameterised by width and depth; ports push, pop, flush, data, empty, full, count). The FSM stays in chronometer_ctrl.

Test Plan:
1. rst 3 cycles, then start_stop at cycle 10 -> chrono_reset high at cycles 11-12, chrono_enable rises at cycle 13, running=1.
2. RUN, lap_reset with record_time=137, then with record_time=402 -> lap_count=2, lap_data=137. lap_rd -> lap_data=402, lap_count=1.
3. Fill 4 laps (10, 20, 30, 40), 5th lap_reset at 50 -> lap_drop pulses 1 cycle, lap_count=4. Lap with simultaneous lap_rd -> head becomes 20, tail entry is the new value, count stays 4.
4. RUN, start_stop and lap_reset in the same cycle at record_time=250 -> lap 250 stored, PAUSE, enable=0. start_stop -> RUN with no chrono_reset pulse.
5. RUN until record_time=999 (LIMIT 1000) -> overflow=1, enable=0 next cycle; start_stop ignored. lap_reset -> 2-cycle chrono_reset, IDLE, lap_empty=1, overflow=0.
6. rst asserted during the 2nd cycle of CLEAR with 3 laps stored -> next cycle IDLE, all outputs at reset values, lap_count=0.
